spi_instruction_fetch: RTL and testbench

Serial instruction fetch unit that sits directly upstream of the single-cycle CPU's instruction port. It replaces the on-chip ROM with external SPI NOR flash. On a fetch request it issues a standard READ (0x03) transaction and assembles the little-endian 32-bit instruction word. It then presents the word to the CPU with a one-cycle ready pulse, holding it until the next fetch completes.

---
 rtl/spi_instruction_fetch_if.sv | 25 ++
 rtl/spi_instruction_fetch.sv | 152 +++++++++++++++
 tb/tb_spi_instruction_fetch.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_instruction_fetch_if.sv
// Fetch-side handshake between the CPU instruction port and the SPI fetch unit.
//   request     CPU -> fetch  start a fetch (sampled only while the unit is idle)
//   address     CPU -> fetch  byte address of the word to fetch
//   busy        fetch -> CPU  unit is in a transaction (any state but idle)
//   ready       fetch -> CPU  one-cycle pulse, instruction updated this cycle
//   instruction fetch -> CPU  last fetched word, held between fetches
interface spi_instruction_fetch_if #(
    parameter int ADDRESS_WIDTH = 24
);
    logic                     request;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     busy;
    logic                     ready;
    logic [31:0]              instruction;

    modport master (
        output request, address,
        input  busy, ready, instruction
    );

    modport slave (
        input  request, address,
        output busy, ready, instruction
    );
endinterface

// File: rtl/spi_instruction_fetch.sv
// SPI NOR instruction fetch unit. On an accepted request it runs one READ
// transaction (opcode, 24-bit word-aligned address, 32 data bits) in SPI
// mode 0 at clock/2 and presents the little-endian word to the CPU.
// Ports:
//   clock, reset_n  single clock, synchronous active-low reset
//   fetch           slave side of spi_instruction_fetch_if
//   spi_cs_n        flash chip select, active low
//   spi_sck         SPI clock (mode 0)
//   spi_mosi        serial data to flash, MSB first
//   spi_miso        serial data from flash
module spi_instruction_fetch #(
    parameter int          ADDRESS_WIDTH     = 24,
    parameter logic [7:0]  READ_COMMAND      = 8'h03,
    parameter logic [31:0] RESET_INSTRUCTION = 32'h0000_0013
) (
    input  logic                    clock,
    input  logic                    reset_n,
    spi_instruction_fetch_if.slave  fetch,
    output logic                    spi_cs_n,
    output logic                    spi_sck,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);

    typedef enum logic [2:0] {IDLE, COMMAND, ADDRESS, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] tx_q, tx_d;          // {opcode, address}, shifted out MSB first
    logic [31:0] rx_q, rx_d;
    logic [31:0] instruction_q, instruction_d;
    logic        cs_n_q, cs_n_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;

    logic [23:0] addr_ext;
    logic [5:0]  last_bit;
    logic        bit_end;

    // Word-aligned, zero-extended flash address.
    assign addr_ext = 24'(fetch.address) & 24'hFF_FFFC;

    // A bit ends at the edge closing its sck-high phase.
    assign bit_end = phase_q && (state_q inside {COMMAND, ADDRESS, DATA});

    always_comb begin
        case (state_q)
            COMMAND: last_bit = 6'd7;
            ADDRESS: last_bit = 6'd23;
            default: last_bit = 6'd31;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            phase_q       <= 1'b0;
            bit_cnt_q     <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            instruction_q <= RESET_INSTRUCTION;
            cs_n_q        <= 1'b1;
            sck_q         <= 1'b0;
            mosi_q        <= 1'b0;
            busy_q        <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            instruction_q <= instruction_d;
            cs_n_q        <= cs_n_d;
            sck_q         <= sck_d;
            mosi_q        <= mosi_d;
            busy_q        <= busy_d;
            ready_q       <= ready_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (fetch.request) begin
                    state_d   = COMMAND;
                    phase_d   = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            COMMAND, ADDRESS, DATA: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (bit_cnt_q == last_bit) begin
                        bit_cnt_d = '0;
                        case (state_q)
                            COMMAND: state_d = ADDRESS;
                            ADDRESS: state_d = DATA;
                            default: state_d = DONE;
                        endcase
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic; every output is registered from its _d value.
    always_comb begin
        tx_d          = tx_q;
        rx_d          = rx_q;
        instruction_d = instruction_q;

        if (state_q == IDLE && fetch.request)
            tx_d = {READ_COMMAND, addr_ext};
        else if (bit_end && state_q inside {COMMAND, ADDRESS})
            tx_d = {tx_q[30:0], 1'b0};

        if (bit_end && state_q == DATA)
            rx_d = {rx_q[30:0], spi_miso};

        ready_d = (state_q == DATA) && (state_d == DONE);
        // First received byte sits in rx[31:24]; it is the word's low byte.
        if (ready_d)
            instruction_d = {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]};

        cs_n_d = !(state_d inside {COMMAND, ADDRESS, DATA});
        sck_d  = !cs_n_d && phase_d;
        busy_d = (state_d != IDLE);
        // tx only moves at the end of a bit, so mosi is stable while sck is high.
        mosi_d = (state_d inside {COMMAND, ADDRESS}) ? tx_d[31] : 1'b0;
    end

    assign spi_cs_n          = cs_n_q;
    assign spi_sck           = sck_q;
    assign spi_mosi          = mosi_q;
    assign fetch.busy        = busy_q;
    assign fetch.ready       = ready_q;
    assign fetch.instruction = instruction_q;

endmodule

// File: tb/tb_spi_instruction_fetch.sv
// Bench for spi_instruction_fetch: a behavioural SPI NOR flash answers READ
// transactions from a byte array; expected words and timing come from the
// fetch rules (word = four bytes from the aligned address, little-endian;
// ready at cycle 129 after acceptance).
module tb_spi_instruction_fetch;

    logic clock;
    logic reset_n;
    logic spi_cs_n, spi_sck, spi_mosi;
    logic spi_miso = 1'b0;

    spi_instruction_fetch_if #(.ADDRESS_WIDTH(24)) fif ();

    spi_instruction_fetch #(.ADDRESS_WIDTH(24)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .fetch    (fif),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- flash model ----------------
    logic [7:0]  flash [256];
    int          rises;
    logic [63:0] mosi_bits;
    logic [23:0] rd_addr;
    logic [7:0]  txn_cmd_q[$];
    logic [23:0] txn_addr_q[$];
    int          txn_rises_q[$];
    logic [31:0] txn_dmosi_q[$];

    always @(negedge spi_cs_n or posedge spi_sck) begin
        if (spi_sck === 1'b1) begin
            if (spi_cs_n === 1'b0) begin
                mosi_bits = {mosi_bits[62:0], spi_mosi};
                rises++;
            end
        end else begin
            rises     = 0;
            mosi_bits = '0;
        end
    end

    // Mode 0: next read bit goes out on the falling sck edge.
    always @(negedge spi_sck) begin
        if (spi_cs_n === 1'b0 && rises >= 32 && rises < 64) begin
            if (rises == 32) rd_addr = mosi_bits[23:0];
            spi_miso = flash[(int'(rd_addr) + (rises - 32) / 8) & 255][7 - (rises - 32) % 8];
        end
    end

    always @(posedge spi_cs_n) begin
        txn_cmd_q.push_back(mosi_bits[63:56]);
        txn_addr_q.push_back(mosi_bits[55:32]);
        txn_rises_q.push_back(rises);
        txn_dmosi_q.push_back(mosi_bits[31:0]);
    end

    function automatic logic [31:0] word_at(input logic [23:0] a);
        int b;
        b = int'(a[7:0]) & 8'hFC;
        return {flash[b + 3], flash[b + 2], flash[b + 1], flash[b]};
    endfunction

    task automatic clear_txn();
        txn_cmd_q.delete();
        txn_addr_q.delete();
        txn_rises_q.delete();
        txn_dmosi_q.delete();
    endtask

    // ---------------- cycle monitor ----------------
    int          ready_q[$];
    logic [31:0] rdy_instr_q[$];
    int          instr_chg_q[$];
    logic        cs_hist   [300];
    logic        busy_hist [300];
    logic        sck_hist  [300];
    int          mosi_viol;

    // Samples mid-cycle; cycle 1 is the cycle after the acceptance edge.
    task automatic watch(input int n);
        logic [31:0] prev_instr;
        logic        prev_mosi;
        ready_q.delete();
        rdy_instr_q.delete();
        instr_chg_q.delete();
        mosi_viol  = 0;
        prev_instr = fif.instruction;
        prev_mosi  = spi_mosi;
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            cs_hist[c]   = spi_cs_n;
            busy_hist[c] = fif.busy;
            sck_hist[c]  = spi_sck;
            if (fif.ready === 1'b1) begin
                ready_q.push_back(c);
                rdy_instr_q.push_back(fif.instruction);
            end
            if (fif.instruction !== prev_instr) instr_chg_q.push_back(c);
            if (spi_sck === 1'b1 && spi_mosi !== prev_mosi) mosi_viol++;
            prev_instr = fif.instruction;
            prev_mosi  = spi_mosi;
        end
    endtask

    // mode 0: request dropped after acceptance
    // mode 1: request+address 0x10 pulsed at cycle 60
    // mode 2: request/address randomly toggled while busy
    task automatic run_fetch(input logic [23:0] addr, input int mode);
        logic [31:0] exp;
        int cs_bad, busy_bad, sck_bad, stray_chg;
        clear_txn();
        exp = word_at(addr);
        @(negedge clock);
        fif.request = 1'b1;
        fif.address = addr;
        fork
            begin
                for (int c = 1; c <= 130; c++) begin
                    @(negedge clock);
                    fif.request = 1'b0;
                    if (mode == 1 && c == 60) begin
                        fif.request = 1'b1;
                        fif.address = 24'h10;
                    end
                    if (mode == 2 && c < 130) begin
                        fif.request = 1'($urandom);
                        fif.address = 24'($urandom);
                    end
                end
            end
            watch(130);
        join
        cs_bad = 0; busy_bad = 0; sck_bad = 0; stray_chg = 0;
        for (int c = 1; c <= 130; c++) begin
            if (cs_hist[c] !== (c >= 129)) cs_bad++;
            if (busy_hist[c] !== (c <= 129)) busy_bad++;
            if (sck_hist[c] !== (c <= 128 && c % 2 == 0)) sck_bad++;
        end
        foreach (instr_chg_q[i]) if (instr_chg_q[i] != 129) stray_chg++;
        chk("ready_count", ready_q.size(), 1);
        chk("ready_cycle", ready_q.size() > 0 ? ready_q[0] : -1, 129);
        chk("ready_word", rdy_instr_q.size() > 0 ? rdy_instr_q[0] : 'x, exp);
        chk("instruction", fif.instruction, exp);
        chk("cs_pattern_errs", cs_bad, 0);
        chk("busy_pattern_errs", busy_bad, 0);
        chk("sck_pattern_errs", sck_bad, 0);
        chk("instr_early_change", stray_chg, 0);
        chk("mosi_change_sck_high", mosi_viol, 0);
        chk("txn_count", txn_cmd_q.size(), 1);
        chk("txn_cmd", txn_cmd_q.size() > 0 ? txn_cmd_q[0] : 'x, 8'h03);
        chk("txn_addr", txn_addr_q.size() > 0 ? txn_addr_q[0] : 'x, addr & 24'hFF_FFFC);
        chk("txn_sck_rises", txn_rises_q.size() > 0 ? txn_rises_q[0] : -1, 64);
        chk("txn_data_mosi", txn_dmosi_q.size() > 0 ? txn_dmosi_q[0] : 'x, 0);
    endtask

    task automatic idle_reset_check(input string tag);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk({tag, "_cs_n"}, spi_cs_n, 1);
        chk({tag, "_sck"}, spi_sck, 0);
        chk({tag, "_mosi"}, spi_mosi, 0);
        chk({tag, "_busy"}, fif.busy, 0);
        chk({tag, "_ready"}, fif.ready, 0);
        chk({tag, "_instr"}, fif.instruction, 32'h0000_0013);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        fif.request = 1'b0;
        fif.address = '0;
        for (int i = 0; i < 256; i++) flash[i] = 8'($urandom);
        flash[4] = 8'h23; flash[5] = 8'h2E; flash[6] = 8'h81; flash[7] = 8'h00;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        idle_reset_check("reset");

        // basic fetch
        run_fetch(24'h000004, 0);
        chk("basic_word", fif.instruction, 32'h0081_2E23);
        idle_reset_check("reset_after_fetch");

        // alignment: low address bits ignored
        run_fetch(24'h000007, 0);
        chk("align_word", fif.instruction, 32'h0081_2E23);

        // request during a fetch is ignored
        run_fetch(24'h000004, 1);

        // back-to-back with request held high
        clear_txn();
        @(negedge clock);
        fif.request = 1'b1;
        fif.address = 24'h0;
        fork
            begin
                @(negedge clock);
                fif.address = 24'h8;
                repeat (130) @(negedge clock);
                fif.request = 1'b0;
            end
            watch(262);
        join
        chk("b2b_ready_count", ready_q.size(), 2);
        chk("b2b_ready0_cycle", ready_q.size() > 0 ? ready_q[0] : -1, 129);
        chk("b2b_ready1_cycle", ready_q.size() > 1 ? ready_q[1] : -1, 259);
        chk("b2b_word0", rdy_instr_q.size() > 0 ? rdy_instr_q[0] : 'x, word_at(24'h0));
        chk("b2b_word1", rdy_instr_q.size() > 1 ? rdy_instr_q[1] : 'x, word_at(24'h8));
        chk("b2b_cs_128", cs_hist[128], 0);
        chk("b2b_cs_129", cs_hist[129], 1);
        chk("b2b_cs_130", cs_hist[130], 1);
        chk("b2b_cs_131", cs_hist[131], 0);
        chk("b2b_busy_130", busy_hist[130], 0);
        chk("b2b_txn_count", txn_addr_q.size(), 2);
        chk("b2b_txn_addr0", txn_addr_q.size() > 0 ? txn_addr_q[0] : 'x, 24'h0);
        chk("b2b_txn_addr1", txn_addr_q.size() > 1 ? txn_addr_q[1] : 'x, 24'h8);

        // reset during the address phase
        @(negedge clock);
        fif.request = 1'b1;
        fif.address = 24'h4;
        fork
            begin
                @(negedge clock);
                fif.request = 1'b0;
                repeat (39) @(negedge clock);
                reset_n = 1'b0;
                @(negedge clock);
                reset_n = 1'b1;
            end
            watch(140);
        join
        chk("mid_reset_cs_40", cs_hist[40], 0);
        chk("mid_reset_cs_41", cs_hist[41], 1);
        chk("mid_reset_busy_41", busy_hist[41], 0);
        chk("mid_reset_sck_41", sck_hist[41], 0);
        chk("mid_reset_no_ready", ready_q.size(), 0);
        chk("mid_reset_instr", fif.instruction, 32'h0000_0013);
        run_fetch(24'h000004, 0);

        // random addresses with request noise while busy
        repeat (6) run_fetch(24'($urandom_range(0, 255)), 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
